// File: rtl/stack_req_if.sv
// stack_req_if: host command/response channels plus the level-handshake lines toward the stack unit.
interface stack_req_if #(
  parameter int DATA_SIZE = 32,
  parameter int N_SIZE = 10,
  parameter int OP_SIZE = 3,
  parameter int CNT_SIZE = 16
);
  logic cmd_valid, cmd_ready;
  logic [OP_SIZE-1:0] cmd_op;
  logic [DATA_SIZE-1:0] cmd_data;
  logic [N_SIZE-1:0] cmd_n;
  logic [OP_SIZE-1:0] op_out;
  logic [DATA_SIZE-1:0] datain_out;
  logic [N_SIZE-1:0] n_out;
  logic rdy_out, ack_in, esito_in;
  logic [DATA_SIZE-1:0] dataout_in;
  logic resp_valid, resp_ready, resp_esito, resp_timeout, proto_err;
  logic [DATA_SIZE-1:0] resp_data;
  logic [CNT_SIZE-1:0] txn_count;
  modport master (
    input cmd_valid, cmd_op, cmd_data, cmd_n, ack_in, dataout_in, esito_in, resp_ready,
    output cmd_ready, op_out, datain_out, n_out, rdy_out, resp_valid, resp_data, resp_esito,
    resp_timeout, proto_err, txn_count
  );
  modport slave (
    output cmd_valid, cmd_op, cmd_data, cmd_n, ack_in, dataout_in, esito_in, resp_ready,
    input cmd_ready, op_out, datain_out, n_out, rdy_out, resp_valid, resp_data, resp_esito,
    resp_timeout, proto_err, txn_count
  );
endinterface

// File: rtl/stack_requester.sv
// stack_requester: initiator of the stack unit's rdy/ack level-toggle protocol with a host valid/ready front end.
// Define TIMEOUT_EN to abandon a request after TIMEOUT_CYCLES cycles in REQ without an ack.
module stack_requester #(
  parameter int DATA_SIZE = 32,
  parameter int N_SIZE = 10,
  parameter int OP_SIZE = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_SIZE = 16
) (
  input logic clock,
  input logic reset_n,
  stack_req_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  logic [1:0] state;
  logic rdy, ack_exp, resp_valid, resp_esito, proto_err, resp_timeout, ack_event, tmo_hit;
  logic [OP_SIZE-1:0] op;
  logic [DATA_SIZE-1:0] datain, resp_data;
  logic [N_SIZE-1:0] n;
  logic [CNT_SIZE-1:0] txn_count;
  assign ack_event = bus.ack_in != ack_exp;
  assign bus.cmd_ready = state == IDLE;
  assign bus.op_out = op;
  assign bus.datain_out = datain;
  assign bus.n_out = n;
  assign bus.rdy_out = rdy;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_data = resp_data;
  assign bus.resp_esito = resp_esito;
  assign bus.resp_timeout = resp_timeout;
  assign bus.proto_err = proto_err;
  assign bus.txn_count = txn_count;
`ifdef TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  assign tmo_hit = state == REQ && !ack_event && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
  // Held at zero outside REQ, so it is already cleared on entry.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
      resp_timeout <= 1'b0;
    end else begin
      tmo_cnt <= (state == REQ && !ack_event) ? tmo_cnt + 1'b1 : '0;
      resp_timeout <= (state == REQ) ? (!ack_event && tmo_hit) : resp_timeout;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign resp_timeout = 1'b0;
`endif
  // Every ack toggle is consumed; outside REQ it can only be stale or spurious.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      rdy <= 1'b0;
      ack_exp <= 1'b0;
      op <= '0;
      datain <= '0;
      n <= '0;
      resp_valid <= 1'b0;
      resp_data <= '0;
      resp_esito <= 1'b0;
      proto_err <= 1'b0;
      txn_count <= '0;
    end else begin
      ack_exp <= bus.ack_in;
      proto_err <= proto_err | (ack_event && state != REQ);
      if (state == IDLE && bus.cmd_valid) begin
        op <= bus.cmd_op;
        datain <= bus.cmd_data;
        n <= bus.cmd_n;
        rdy <= ~rdy;
        state <= REQ;
      end else if (state == REQ && ack_event) begin
        resp_data <= bus.dataout_in;
        resp_esito <= bus.esito_in;
        txn_count <= txn_count + 1'b1;
        resp_valid <= 1'b1;
        state <= RESP;
      end else if (tmo_hit) begin
        resp_data <= '0;
        resp_esito <= 1'b0;
        resp_valid <= 1'b1;
        state <= RESP;
      end else if (state == RESP && bus.resp_ready) begin
        resp_valid <= 1'b0;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_stack_requester.sv
// tb_stack_requester: directed stimulus with a response scoreboard; the bench plays host and stack unit.
module tb_stack_requester;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [33:0] exp_q[$];
  stack_req_if #(.DATA_SIZE(32), .N_SIZE(10), .OP_SIZE(3), .CNT_SIZE(16)) bus ();
  stack_requester #(
    .DATA_SIZE(32), .N_SIZE(10), .OP_SIZE(3), .TIMEOUT_CYCLES(8), .CNT_SIZE(16)
  ) dut (
    .clock(clk),
    .reset_n(reset_n),
    .bus(bus.master)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    bus.ack_in = 1'b0;
    bus.cmd_valid = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask
  task automatic send(input logic [2:0] op, input logic [31:0] data, input logic [9:0] n);
    int k = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_data = data;
    bus.cmd_n = n;
    while (!bus.cmd_ready && k < 50) begin
      tick();
      k++;
    end
    chk("cmd_accept_wait", 64'(k < 50), 64'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask
  task automatic give_ack(input logic [31:0] d, input logic e);
    bus.dataout_in = d;
    bus.esito_in = e;
    bus.ack_in = ~bus.ack_in;
    exp_q.push_back({d, e, 1'b0});
  endtask
  always @(negedge clk) begin
    if (reset_n && bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) chk("resp_unexpected", 64'd1, 64'd0);
      else chk("resp", 64'({bus.resp_data, bus.resp_esito, bus.resp_timeout}), 64'(exp_q.pop_front()));
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_data = '0;
    bus.cmd_n = '0;
    bus.ack_in = 1'b0;
    bus.dataout_in = '0;
    bus.esito_in = 1'b0;
    bus.resp_ready = 1'b1;
    do_reset();
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_rdy", 64'(bus.rdy_out), 64'd0);
    chk("rst_op", 64'(bus.op_out), 64'd0);
    chk("rst_datain", 64'(bus.datain_out), 64'd0);
    chk("rst_n", 64'(bus.n_out), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_data", 64'(bus.resp_data), 64'd0);
    chk("rst_resp_esito", 64'(bus.resp_esito), 64'd0);
    chk("rst_resp_timeout", 64'(bus.resp_timeout), 64'd0);
    chk("rst_proto_err", 64'(bus.proto_err), 64'd0);
    chk("rst_txn", 64'(bus.txn_count), 64'd0);
    bus.ack_in = 1'b1;
    tick();
    chk("spurious_proto_err", 64'(bus.proto_err), 64'd1);
    chk("spurious_no_resp", 64'(bus.resp_valid), 64'd0);
    chk("spurious_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    // single command
    do_reset();
    chk("single_proto_cleared", 64'(bus.proto_err), 64'd0);
    send(3'b001, 32'hDEADBEEF, 10'd5);
    chk("single_rdy", 64'(bus.rdy_out), 64'd1);
    chk("single_op", 64'(bus.op_out), 64'd1);
    chk("single_datain", 64'(bus.datain_out), 64'hDEADBEEF);
    chk("single_n", 64'(bus.n_out), 64'd5);
    repeat (3) tick();
    chk("single_hold_datain", 64'(bus.datain_out), 64'hDEADBEEF);
    chk("single_hold_n", 64'(bus.n_out), 64'd5);
    chk("single_no_resp_yet", 64'(bus.resp_valid), 64'd0);
    give_ack(32'h12345678, 1'b1);
    tick();
    chk("single_resp_valid", 64'(bus.resp_valid), 64'd1);
    chk("single_cmd_ready_resp", 64'(bus.cmd_ready), 64'd0);
    tick();
    chk("single_txn", 64'(bus.txn_count), 64'd1);
    chk("single_resp_cleared", 64'(bus.resp_valid), 64'd0);
    chk("single_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    // three back-to-back
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(3'(i), 32'hA0 + 32'(i), 10'(i));
      chk("b2b_rdy", 64'(bus.rdy_out), 64'(i % 2 == 0));
      tick();
      give_ack(32'hC0 + 32'(i), i[0]);
      tick();
      tick();
    end
    chk("b2b_txn", 64'(bus.txn_count), 64'd3);
    chk("b2b_proto", 64'(bus.proto_err), 64'd0);
    // response backpressure with a pending command
    do_reset();
    bus.resp_ready = 1'b0;
    send(3'd2, 32'h11111111, 10'd7);
    tick();
    give_ack(32'h55AA55AA, 1'b0);
    tick();
    chk("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'd4;
    bus.cmd_data = 32'h22222222;
    bus.cmd_n = 10'd9;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_resp_data", 64'(bus.resp_data), 64'h55AA55AA);
      chk("bp_resp_valid_hold", 64'(bus.resp_valid), 64'd1);
      chk("bp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      chk("bp_rdy_hold", 64'(bus.rdy_out), 64'd1);
    end
    bus.resp_ready = 1'b1;
    tick();
    chk("bp_after_hs_valid", 64'(bus.resp_valid), 64'd0);
    chk("bp_after_hs_rdy", 64'(bus.rdy_out), 64'd1);
    chk("bp_after_hs_ready", 64'(bus.cmd_ready), 64'd1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("bp_accept_rdy", 64'(bus.rdy_out), 64'd0);
    chk("bp_accept_data", 64'(bus.datain_out), 64'h22222222);
    give_ack(32'h33333333, 1'b1);
    tick();
    tick();
    chk("bp_txn", 64'(bus.txn_count), 64'd2);
    // reset while a request is outstanding
    do_reset();
    send(3'd5, 32'h44444444, 10'd3);
    tick();
    reset_n = 1'b0;
    bus.ack_in = 1'b0;
    tick();
    chk("midrst_rdy", 64'(bus.rdy_out), 64'd0);
    chk("midrst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("midrst_resp", 64'(bus.resp_valid), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("midrst_no_resp", 64'(bus.resp_valid), 64'd0);
    send(3'd6, 32'h66666666, 10'd1);
    tick();
    give_ack(32'h77777777, 1'b1);
    tick();
    tick();
    chk("midrst_txn", 64'(bus.txn_count), 64'd1);
    chk("midrst_proto", 64'(bus.proto_err), 64'd0);
`ifdef TIMEOUT_EN
    do_reset();
    begin
      int k = 0;
      exp_q.push_back({32'h0, 1'b0, 1'b1});
      send(3'd7, 32'h88888888, 10'd2);
      while (!bus.resp_valid && k < 20) begin
        tick();
        k++;
      end
      chk("tmo_cycles", 64'(k), 64'd8);
      chk("tmo_flag", 64'(bus.resp_timeout), 64'd1);
      chk("tmo_txn", 64'(bus.txn_count), 64'd0);
      tick();
      bus.ack_in = ~bus.ack_in;
      tick();
      chk("tmo_late_proto", 64'(bus.proto_err), 64'd1);
      chk("tmo_late_no_resp", 64'(bus.resp_valid), 64'd0);
      send(3'd1, 32'h99999999, 10'd4);
      tick();
      give_ack(32'hABCDEF01, 1'b1);
      tick();
      chk("tmo_next_timeout_flag", 64'(bus.resp_timeout), 64'd0);
      tick();
      chk("tmo_next_txn", 64'(bus.txn_count), 64'd1);
    end
`endif
    repeat (3) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stack_requester.md
Name: stack_requester

Overview:
- Initiator side of the stack unit's level-transition request/acknowledge protocol.
- Accepts commands (op, data word, N) from a local host over a valid/ready handshake.
- Drives op/datain/N and a toggling rdy level toward the stack unit, then waits for the unit's ack level toggle.
- Captures dataout and esito and returns them to the host over a valid/ready response channel.

Parameters:
- DATA_SIZE, 32, width of data word toward the unit and of the returned dataout.
- N_SIZE, 10, width of the N operand.
- OP_SIZE, 3, width of the opcode. Passed through opaquely; never decoded here.
- TIMEOUT_CYCLES, 1024, REQ-state cycles without ack before a timeout response (TIMEOUT_EN only).
- CNT_SIZE, 16, width of the completed-transaction counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  host command present.
- cmd_ready  out  1  block accepts a command this cycle.
- cmd_op  in  OP_SIZE  opcode.
- cmd_data  in  DATA_SIZE  operand word.
- cmd_n  in  N_SIZE  N operand.
- op_out  out  OP_SIZE  opcode to the stack unit.
- datain_out  out  DATA_SIZE  data to the stack unit.
- n_out  out  N_SIZE  N to the stack unit.
- rdy_out  out  1  request level; toggles once per request.
- ack_in  in  1  ack level from the unit; toggles once per completion.
- dataout_in  in  DATA_SIZE  result word from the unit.
- esito_in  in  1  outcome bit from the unit.
- resp_valid  out  1  response present.
- resp_ready  in  1  host takes the response.
- resp_data  out  DATA_SIZE  captured dataout.
- resp_esito  out  1  captured esito.
- resp_timeout  out  1  response produced by timeout; constant 0 without TIMEOUT_EN.
- proto_err  out  1  sticky flag: ack toggle seen while no request outstanding.
- txn_count  out  CNT_SIZE  completed transactions; wraps modulo 2^CNT_SIZE.

Behaviour:
- Reset (reset_n=0 at a clock edge) forces state IDLE and clears:
  - rdy_out, ack_exp, op_out, datain_out, n_out
  - resp_valid, resp_data, resp_esito, resp_timeout
  - proto_err, txn_count, timeout counter
- Reset mid-transaction abandons the transaction with no response. The stack unit must be reset in the same cycle; the level pair is realigned to 0/0.
- ack_exp is an internal register holding the last consumed ack level. ack_event = (ack_in != ack_exp), combinational, same cycle.
- States:
  - IDLE: cmd_ready=1. On cmd_valid: register op/data/n into op_out/datain_out/n_out, toggle rdy_out, go to REQ. All take effect at the same edge, so outputs update 1 cycle after acceptance.
  - REQ: cmd_ready=0. op_out/datain_out/n_out held stable, since the unit samples them every cycle. On ack_event: capture dataout_in→resp_data and esito_in→resp_esito, toggle ack_exp, increment txn_count, set resp_valid, go to RESP. resp_valid rises 1 cycle after ack_event.
  - RESP: cmd_ready=0. resp_* held stable. On resp_ready: clear resp_valid, go to IDLE. No new command is accepted in that same cycle.
- Minimum request-to-response latency: accept at cycle t, rdy toggles at t+1, earliest ack_event at t+1, resp_valid at t+2.
- ack_event in IDLE or RESP (stale/spurious ack): toggle ack_exp to absorb it and set proto_err. No response is generated and state is unchanged. proto_err clears only on reset.
- rdy_out never toggles twice without an intervening consumed ack, except after a timeout (see Optional Feature).
- Back-to-back commands: at most one outstanding request; throughput is one transaction per 3 cycles minimum.

Optional Feature:
- Macro TIMEOUT_EN.
- With it defined:
  - A counter clears on entry to REQ and increments each REQ cycle without ack_event.
  - When it reaches TIMEOUT_CYCLES-1 with no ack_event: go to RESP with resp_timeout=1, resp_data=0, resp_esito=0. ack_exp is not toggled and txn_count is not incremented.
  - The late ack is later absorbed as stale and sets proto_err.
  - ack_event and timeout in the same cycle: the ack wins.
- Without it: no counter; the block waits in REQ indefinitely; resp_timeout is constant 0.

Test Plan:
- Reset then idle: all outputs 0, cmd_ready=1; toggling ack_in once sets proto_err=1 with no resp_valid.
- Single command op=3'b001, data=32'hDEADBEEF, n=10'd5, accepted at t: rdy_out=1 at t+1, operands stable. ack_in 0→1 at t+4 with dataout_in=32'h12345678, esito_in=1: resp_valid at t+5 with those values; txn_count=1.
- Three back-to-back commands with resp_ready held 1 and ack returned 2 cycles after each rdy toggle: rdy_out toggles 1,0,1; three responses in order; txn_count=3; proto_err=0.
- Response backpressure: resp_ready=0 for 10 cycles after resp_valid: resp_data/resp_esito stable, cmd_ready=0, a pending cmd_valid is not accepted until after the handshake.
- Reset asserted in REQ: next cycle rdy_out=0, state IDLE, no response. A subsequent command completes normally with the unit also reset.
- TIMEOUT_EN with TIMEOUT_CYCLES=8 and no ack: resp_valid with resp_timeout=1 after 8 REQ cycles. A late ack then sets proto_err=1, and the next command completes normally.
